// File: rtl/pool_window_feeder_pkg.sv
// Shared types for the pooling window feeder: pixel/window typedefs and FSM states.
package pool_window_feeder_pkg;

  localparam int PIX_W_DEF = 16;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  typedef struct packed {
    pix_t w00;
    pix_t w01;
    pix_t w10;
    pix_t w11;
  } win_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVEN_ROW,
    ST_ODD_ROW,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pool_window_feeder_line_buf.sv
// pool_line_buf: one-row pixel store with one write port and two asynchronous read ports.
module pool_line_buf #(
  parameter int DEPTH = 28,
  parameter int PIX_W = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [PIX_W-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [PIX_W-1:0] rd_data_b
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; every entry is written in the even row before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/pool_window_feeder.sv
// Raster pixel stream -> stride-2 2x2 pooling windows with a single-entry output register.
// Optional accepted-window counter output enabled by defining POOL_FEEDER_WIN_CNT_EN.
module pool_window_feeder
  import pool_window_feeder_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] win_00,
  output logic [PIX_W-1:0] win_01,
  output logic [PIX_W-1:0] win_10,
  output logic [PIX_W-1:0] win_11,
  output logic             win_valid,
  input  logic             win_ready,
`ifdef POOL_FEEDER_WIN_CNT_EN
  output logic [15:0]      win_count,
`endif
  output logic             frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic last_q, last_d;
  logic [PIX_W-1:0] held_q, held_d;
  logic [3:0][PIX_W-1:0] win_q, win_d;
  logic win_valid_q, win_valid_d;

  logic pix_xfer, win_xfer, out_free, col_end, row_end;
  logic [PIX_W-1:0] rd_prev, rd_cur;

  assign pix_xfer = pix_valid && pix_ready;
  assign win_xfer = win_valid_q && win_ready;
  assign out_free = !win_valid_q || win_ready;
  assign col_end  = (col_q == COL_LAST);
  assign row_end  = (row_q == ROW_LAST);

  pool_line_buf #(
    .DEPTH (IMG_W),
    .PIX_W (PIX_W)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (pix_xfer && (state_q == ST_EVEN_ROW)),
    .wr_addr   (col_q),
    .wr_data   (pix_in),
    .rd_addr_a (col_q - CW'(1)),
    .rd_data_a (rd_prev),
    .rd_addr_b (col_q),
    .rd_data_b (rd_cur)
  );

  // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
      held_q      <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      last_q      <= last_d;
      held_q      <= held_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

  // last_q marks "all pixels of the frame consumed"; the FSM then waits for the output register to drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (frame_start) state_d = ST_EVEN_ROW;
      ST_EVEN_ROW: begin
        if (last_q) begin
          if (out_free) state_d = ST_DONE;
        end else if (pix_xfer && col_end && !row_end) begin
          state_d = ST_ODD_ROW;
        end
      end
      ST_ODD_ROW: begin
        if (last_q) begin
          if (out_free) state_d = ST_DONE;
        end else if (pix_xfer && col_end && !row_end) begin
          state_d = ST_EVEN_ROW;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pix_ready  = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_EVEN_ROW: pix_ready = !last_q;
      ST_ODD_ROW:  pix_ready = !last_q && (!col_q[0] || out_free);
      ST_DONE:     frame_done = 1'b1;
      default:     pix_ready = 1'b0;
    endcase
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    last_d      = last_q;
    held_d      = held_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;

    if (state_q == ST_IDLE) begin
      col_d  = '0;
      row_d  = '0;
      last_d = 1'b0;
    end

    if (pix_xfer) begin
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d  = '0;
          last_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (win_xfer) win_valid_d = 1'b0;

    // A simultaneous accept and reload keeps win_valid high with the new window.
    if (pix_xfer && (state_q == ST_ODD_ROW)) begin
      if (!col_q[0]) begin
        held_d = pix_in;
      end else begin
        win_d       = {rd_prev, rd_cur, held_q, pix_in};
        win_valid_d = 1'b1;
      end
    end
  end

  assign win_00    = win_q[3];
  assign win_01    = win_q[2];
  assign win_10    = win_q[1];
  assign win_11    = win_q[0];
  assign win_valid = win_valid_q;

`ifdef POOL_FEEDER_WIN_CNT_EN
  logic [15:0] win_cnt_q, win_cnt_d;

  always_comb begin
    win_cnt_d = win_cnt_q;
    if ((state_q == ST_IDLE) && frame_start) win_cnt_d = '0;
    else if (win_xfer)                       win_cnt_d = win_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_cnt_q <= '0;
    else     win_cnt_q <= win_cnt_d;
  end

  assign win_count = win_cnt_q;
`endif

endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench for pool_window_feeder: a 4x4 instance and a 5x5 instance on one clock.
module tb_pool_window_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start [2];
  logic [15:0] pix_in      [2];
  logic        pix_valid   [2];
  logic        pix_ready   [2];
  logic [15:0] win_00 [2], win_01 [2], win_10 [2], win_11 [2];
  logic        win_valid   [2];
  logic        win_ready   [2];
  logic        frame_done  [2];
  logic [15:0] win_count   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int win_cnt [2];
  int fd_cnt  [2];
  int pix_cnt = 0;
  logic [63:0] exp_q [$];
  logic        stalled  [2];
  logic [63:0] held_win [2];
  logic [63:0] mon_cur;
  bit          stall_req = 1'b0;
  int          stall_p0;

  always #5 clk = ~clk;

  pool_window_feeder #(.IMG_W(4), .IMG_H(4), .PIX_W(16)) u_dut4 (
    .clk (clk), .rst (rst), .frame_start (frame_start[0]),
    .pix_in (pix_in[0]), .pix_valid (pix_valid[0]), .pix_ready (pix_ready[0]),
    .win_00 (win_00[0]), .win_01 (win_01[0]), .win_10 (win_10[0]), .win_11 (win_11[0]),
    .win_valid (win_valid[0]), .win_ready (win_ready[0]),
`ifdef POOL_FEEDER_WIN_CNT_EN
    .win_count (win_count[0]),
`endif
    .frame_done (frame_done[0])
  );

  pool_window_feeder #(.IMG_W(5), .IMG_H(5), .PIX_W(16)) u_dut5 (
    .clk (clk), .rst (rst), .frame_start (frame_start[1]),
    .pix_in (pix_in[1]), .pix_valid (pix_valid[1]), .pix_ready (pix_ready[1]),
    .win_00 (win_00[1]), .win_01 (win_01[1]), .win_10 (win_10[1]), .win_11 (win_11[1]),
    .win_valid (win_valid[1]), .win_ready (win_ready[1]),
`ifdef POOL_FEEDER_WIN_CNT_EN
    .win_count (win_count[1]),
`endif
    .frame_done (frame_done[1])
  );

`ifndef POOL_FEEDER_WIN_CNT_EN
  assign win_count[0] = '0;
  assign win_count[1] = '0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pv(input int v);
    return 16'(v);
  endfunction

  // Output monitor: pops the scoreboard on each accepted window and checks stall stability.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mon_cur = {win_00[d], win_01[d], win_10[d], win_11[d]};
      if (stalled[d]) begin
        check("win_stable", mon_cur, held_win[d]);
        check("stall_valid", win_valid[d], 1);
      end
      stalled[d]  = win_valid[d] && !win_ready[d] && !rst;
      held_win[d] = mon_cur;
      if (win_valid[d] && win_ready[d]) begin
        if (exp_q.size() == 0) check("win_unexpected", mon_cur, 0);
        else check("win", mon_cur, exp_q.pop_front());
        win_cnt[d]++;
      end
      if (frame_done[d]) fd_cnt[d]++;
    end
  end

  // Holds win_ready low for 5 cycles at the first window of a frame when requested.
  always begin
    @(posedge clk);
    #2;
    if (stall_req && win_valid[0]) begin
      win_ready[0] = 1'b0;
      stall_p0 = pix_cnt;
      repeat (5) @(posedge clk);
      #2;
      check("stall_pix_accepted", pix_cnt - stall_p0, 1);
      check("stall_pix_ready_low", pix_ready[0], 0);
      win_ready[0] = 1'b1;
      stall_req = 1'b0;
    end
  end

  task automatic send_frame(input int d, input int base, input int w, input int h,
                            input bit gaps, input int stop_at, input int fs_mid_at);
    int r, c, budget, wc0, fd0;
    bit rdy;
    wc0 = win_cnt[d];
    fd0 = fd_cnt[d];
    frame_start[d] = 1'b1;
    @(posedge clk); #1;
    frame_start[d] = 1'b0;
    for (int i = 0; i < w * h; i++) begin
      if (i == stop_at) return;
      r = i / w;
      c = i % w;
      if (gaps) begin
        pix_valid[d] = 1'b0;
        @(posedge clk); #1;
      end
      pix_in[d]      = pv(base + i);
      pix_valid[d]   = 1'b1;
      frame_start[d] = (i == fs_mid_at);
      budget = 0;
      do begin
        @(negedge clk);
        rdy = pix_ready[d];
        @(posedge clk);
        budget++;
      end while (!rdy && budget < 50);
      if (!rdy) check("pix_ready_timeout", 0, 1);
      pix_cnt++;
      if ((r % 2 == 1) && (c % 2 == 1))
        exp_q.push_back({pv(base + i - w - 1), pv(base + i - w), pv(base + i - 1), pv(base + i)});
      #1;
      frame_start[d] = 1'b0;
      pix_valid[d]   = 1'b0;
      if ((r % 2 == 1) && (c % 2 == 1)) check("win_latency", win_valid[d], 1);
    end
    budget = 0;
    while (!frame_done[d] && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (!frame_done[d]) check("frame_done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("win_total", win_cnt[d] - wc0, (w / 2) * (h / 2));
    check("frame_done_once", fd_cnt[d] - fd0, 1);
    check("scoreboard_empty", exp_q.size(), 0);
`ifdef POOL_FEEDER_WIN_CNT_EN
    check("win_count", win_count[d], (w / 2) * (h / 2));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_before;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      frame_start[d] = 1'b0;
      pix_in[d]      = '0;
      pix_valid[d]   = 1'b0;
      win_ready[d]   = 1'b1;
      stalled[d]     = 1'b0;
      win_cnt[d]     = 0;
      fd_cnt[d]      = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_pix_ready", pix_ready[d], 0);
      check("rst_win_valid", win_valid[d], 0);
      check("rst_frame_done", frame_done[d], 0);
      check("rst_win", {win_00[d], win_01[d], win_10[d], win_11[d]}, 0);
`ifdef POOL_FEEDER_WIN_CNT_EN
      check("rst_win_count", win_count[d], 0);
`endif
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 4x4 frame, always-ready sink.
    send_frame(0, 1, 4, 4, 1'b0, -1, -1);

    // Same frame with a 5-cycle downstream stall at the first window.
    stall_req = 1'b1;
    send_frame(0, 1, 4, 4, 1'b0, -1, -1);
    check("stall_occurred", stall_req, 0);

    // Reset after 6 pixels, then a clean frame 101..116.
    send_frame(0, 1, 4, 4, 1'b0, 6, -1);
    fd_before = fd_cnt[0];
    rst = 1'b1;
    #1;
    check("midrst_win_valid", win_valid[0], 0);
    check("midrst_win", {win_00[0], win_01[0], win_10[0], win_11[0]}, 0);
    check("midrst_pix_ready", pix_ready[0], 0);
    check("midrst_frame_done", frame_done[0], 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_frame_done", fd_cnt[0] - fd_before, 0);
    send_frame(0, 101, 4, 4, 1'b0, -1, -1);

    // frame_start pulsed mid-frame must be ignored.
    send_frame(0, 1, 4, 4, 1'b0, -1, 9);

    // pix_valid toggling every other cycle.
    send_frame(0, 1, 4, 4, 1'b1, -1, -1);

    // Odd 5x5 frame: last row and column dropped.
    send_frame(1, 1, 5, 5, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool_window_feeder.md
POOL_WINDOW_FEEDER -- requirements
Module: pool_window_feeder

Interface
REQ-001 Parameter: IMG_W, 28, feature-map width in pixels (2..256).
REQ-002 Parameter: IMG_H, 28, feature-map height in rows (2..256).
REQ-003 Parameter: PIX_W, 16, pixel width in bits.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: frame_start  input  1  one-cycle pulse; arms a new frame from IDLE.
REQ-007 Port: pix_in  input  PIX_W  raster-order feature-map pixel from the conv stage.
REQ-008 Port: pix_valid  input  1  pix_in is valid.
REQ-009 Port: pix_ready  output  1  feeder accepts pix_in this cycle.
REQ-010 Port: win_00, win_01, win_10, win_11  output  PIX_W each  2x2 window (row,col), driving pooling-stage image_in[0][0], [0][1], [1][0], [1][1].
REQ-011 Port: win_valid  output  1  window valid; drives the pooling-stage start.
REQ-012 Port: win_ready  input  1  downstream consumes the window this cycle.
REQ-013 Port: frame_done  output  1  one-cycle pulse after the last window of a frame is accepted.

Function
REQ-014 Pixel transfer occurs when pix_valid && pix_ready; window transfer occurs when win_valid && win_ready.
REQ-015 FSM states: IDLE, EVEN_ROW, ODD_ROW, DONE; IDLE->EVEN_ROW on frame_start; EVEN_ROW->ODD_ROW after the last column transfer; ODD_ROW->EVEN_ROW after the last column transfer if rows remain, else ->DONE once the output register is empty; DONE->IDLE after one cycle.
REQ-016 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 advance only on pixel transfer; the column counter wraps to 0 and the row counter increments together.
REQ-017 EVEN_ROW writes each pixel into a line buffer of IMG_W x PIX_W at the column index.
REQ-018 ODD_ROW on even column holds the pixel in a side register; on odd column it loads the output register with win_00=buf[c-1], win_01=buf[c], win_10=held, win_11=pix_in, and sets win_valid.
REQ-019 Stride is 2; with odd IMG_W the last column is consumed but forms no window; with odd IMG_H the last row is consumed and discarded, and DONE follows it.
REQ-020 pix_ready = 0 in IDLE and DONE; in ODD_ROW on an odd column, pix_ready = !win_valid || win_ready (single-entry skid, no window lost or duplicated).
REQ-021 Window contents are stable while win_valid && !win_ready.
REQ-022 Latency: win_valid asserts the cycle after the completing (odd-row, odd-column) pixel transfer.
REQ-023 A frame_start outside IDLE is ignored.
REQ-024 Windows per frame = floor(IMG_W/2)*floor(IMG_H/2); frame_done pulses exactly once per frame.

Reset
REQ-025 On rst: state IDLE, counters 0, win_valid 0, frame_done 0, pix_ready 0, win_* 0; line buffer contents are not reset.
REQ-026 rst mid-frame abandons the frame; no frame_done is issued; the next frame_start begins cleanly.

Configuration
REQ-027 With POOL_FEEDER_WIN_CNT_EN defined: extra output win_count (16 bits) counts accepted windows, clears on frame_start and reset, and holds after frame_done.
REQ-028 Without POOL_FEEDER_WIN_CNT_EN: the port and counter are absent; all other behaviour is identical.

Structure
REQ-029 A shared package holds PIX_W default, the pixel typedef, the 2x2 window struct typedef and the FSM state enum.
REQ-030 The line buffer is a sub-module pool_line_buf (1 write port, 2 read ports, IMG_W deep); the feeder contains the FSM, counters and output register.

Verification
REQ-031 IMG_W=4, IMG_H=4, pixels 1..16, win_ready=1 -> windows (1,2,5,6),(3,4,7,8),(9,10,13,14),(11,12,15,16), then one frame_done pulse.
REQ-032 Same frame with win_ready held 0 for 5 cycles at the first window -> pix_ready drops, window (1,2,5,6) is stable, no loss or duplicate; the sequence matches REQ-031.
REQ-033 IMG_W=5, IMG_H=5, pixels 1..25 -> windows (1,2,6,7),(3,4,8,9),(11,12,16,17),(13,14,18,19); row 5 and column 5 are dropped; frame_done after 25 pixel transfers.
REQ-034 rst asserted after 6 pixels of a 4x4 frame -> outputs are 0 immediately, no frame_done; a new frame with pixels 101..116 gives first window (101,102,105,106).
REQ-035 frame_start pulsed mid-frame -> ignored; the window count stays 4 (win_count=4 when POOL_FEEDER_WIN_CNT_EN is defined).
REQ-036 pix_valid toggling every other cycle on a 4x4 frame -> same four windows as REQ-031.
